// File: rtl/riscv_lsu_mem.sv
// RV32 data memory behind a valid/ready request/response port with LATENCY wait states.
// Sizes, extends and merges loads/stores, flags misaligned/out-of-range/illegal accesses, traces store commits.
module riscv_lsu_mem #(
  parameter string DMemInitFile = "",
  parameter int    DEPTH        = 128,
  parameter int    ADDR_W       = 9,
  parameter int    LATENCY      = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              trc_valid_o,
  output logic [ADDR_W-1:0] trc_addr_o,
  output logic [31:0]       trc_data_o
);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state, state_nxt;

  logic [31:0]       mem [DEPTH];
  logic [3:0]        cnt;
  logic              q_we;
  logic [2:0]        q_funct3;
  logic [ADDR_W-1:0] q_addr;
  logic [31:0]       q_wdata;

  logic              accept, commit;
  logic              c_we;
  logic [2:0]        c_funct3;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [ADDR_W-3:0] widx;
  logic [IDX_W-1:0]  idx;
  logic              bad_f3, misalign, oor, err;
  logic [31:0]       rd_word, ld_data, st_data, merged;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [3:0]        strb;

  assign accept = req_valid_i && req_ready_o;
  // With no wait states the commit edge is the accept edge, so decode straight from the request port.
  assign commit = (state == IDLE) ? (accept && (LATENCY == 0)) : ((state == WAIT) && (cnt == 4'd0));

  always_comb begin
    if (state == IDLE) begin
      c_we = req_we_i;  c_funct3 = req_funct3_i;  c_addr = req_addr_i;  c_wdata = req_wdata_i;
    end else begin
      c_we = q_we;      c_funct3 = q_funct3;      c_addr = q_addr;      c_wdata = q_wdata;
    end
  end

  assign widx = c_addr[ADDR_W-1:2];
  assign idx  = widx[IDX_W-1:0];

  always_comb begin
    bad_f3   = c_we ? (c_funct3 > 3'd2)
                    : (c_funct3 == 3'd3 || c_funct3 == 3'd6 || c_funct3 == 3'd7);
    misalign = ((c_funct3[1:0] == 2'd1) && c_addr[0]) ||
               ((c_funct3[1:0] == 2'd2) && (c_addr[1:0] != 2'd0));
    oor      = 32'(widx) >= DEPTH;
    err      = bad_f3 || misalign || oor;
  end

  always_comb begin
    rd_word = mem[idx];
    ld_byte = rd_word[{c_addr[1:0], 3'b000} +: 8];
    ld_half = rd_word[{c_addr[1], 4'b0000} +: 16];
    case (c_funct3)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = rd_word;
    endcase
    case (c_funct3[1:0])
      2'd0:    begin strb = 4'b0001 << c_addr[1:0]; st_data = {4{c_wdata[7:0]}};  end
      2'd1:    begin strb = 4'b0011 << c_addr[1:0]; st_data = {2{c_wdata[15:0]}}; end
      default: begin strb = 4'b1111;                st_data = c_wdata;            end
    endcase
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = st_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = (LATENCY > 0) ? WAIT : RESP;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == IDLE);
    rsp_valid_o = (state == RESP);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt         <= '0;
      q_we        <= 1'b0;
      q_funct3    <= '0;
      q_addr      <= '0;
      q_wdata     <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      trc_valid_o <= 1'b0;
      trc_addr_o  <= '0;
      trc_data_o  <= '0;
    end else begin
      trc_valid_o <= 1'b0;
      if (accept) begin
        q_we     <= req_we_i;
        q_funct3 <= req_funct3_i;
        q_addr   <= req_addr_i;
        q_wdata  <= req_wdata_i;
        cnt      <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_err_o   <= err;
        rsp_rdata_o <= (c_we || err) ? 32'd0 : ld_data;
        if (c_we && !err) begin
          trc_valid_o <= 1'b1;
          trc_addr_o  <= {c_addr[ADDR_W-1:2], 2'b00};
          trc_data_o  <= merged;
        end
      end
    end
  end

  // Memory has no reset; a store whose commit edge coincides with reset is suppressed.
  always_ff @(posedge clk_i) begin
    if (rst_ni && commit && c_we && !err) mem[idx] <= merged;
  end
endmodule

// File: tb/tb_riscv_lsu_mem.sv
// Bench for riscv_lsu_mem: five instances (LATENCY 0..4) share stimulus; a queue-based scoreboard
// checks every response and store trace, with directed vectors followed by a model-checked random stream.
module tb_riscv_lsu_mem;
  localparam int DEPTH = 128;
  localparam int AW    = 10;
  localparam int NI    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  int            cur = 0;
  logic          req_valid, req_we;
  logic [2:0]    req_f3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          bp_mode, rsp_ready_man;
  logic          bp_rnd = 1'b1;
  logic          rsp_ready;

  logic          req_ready_a [NI];
  logic          rsp_valid_a [NI];
  logic [31:0]   rsp_rdata_a [NI];
  logic          rsp_err_a   [NI];
  logic          trc_valid_a [NI];
  logic [AW-1:0] trc_addr_a  [NI];
  logic [31:0]   trc_data_a  [NI];

  assign rsp_ready = bp_mode ? bp_rnd : rsp_ready_man;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    riscv_lsu_mem #(.DMemInitFile(""), .DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(g)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid && (cur == g)),
      .req_ready_o (req_ready_a[g]),
      .req_we_i    (req_we),
      .req_funct3_i(req_f3),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid_a[g]),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata_a[g]),
      .rsp_err_o   (rsp_err_a[g]),
      .trc_valid_o (trc_valid_a[g]),
      .trc_addr_o  (trc_addr_a[g]),
      .trc_data_o  (trc_data_a[g])
    );
  end

  logic          req_ready, rsp_valid, rsp_err, trc_valid;
  logic [31:0]   rsp_rdata, trc_data;
  logic [AW-1:0] trc_addr;
  assign req_ready = req_ready_a[cur];
  assign rsp_valid = rsp_valid_a[cur];
  assign rsp_rdata = rsp_rdata_a[cur];
  assign rsp_err   = rsp_err_a[cur];
  assign trc_valid = trc_valid_a[cur];
  assign trc_addr  = trc_addr_a[cur];
  assign trc_data  = trc_data_a[cur];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } trc_t;
  rsp_t exp_rsp [$];
  trc_t exp_trc [$];

  // Scoreboard monitor: traces pop on the pulse, responses pop on the handshake.
  logic hold = 1'b0;
  rsp_t held, rr;
  trc_t tt;
  always @(negedge clk) begin
    if (rst_n) begin
      if (trc_valid) begin
        if (exp_trc.size() == 0) chk("trc_unexpected", 32'd1, 32'd0);
        else begin
          tt = exp_trc.pop_front();
          chk("trc_addr", 32'(trc_addr), 32'(tt.addr));
          chk("trc_data", trc_data, tt.data);
        end
      end
      if (rsp_valid && hold) begin
        chk("rsp_hold_rdata", rsp_rdata, held.rdata);
        chk("rsp_hold_err", 32'(rsp_err), 32'(held.err));
      end
      if (rsp_valid && rsp_ready) begin
        hold = 1'b0;
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          rr = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, rr.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(rr.err));
        end
      end else begin
        hold       = rsp_valid;
        held.rdata = rsp_rdata;
        held.err   = rsp_err;
      end
    end else begin
      hold = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    bp_rnd = ($urandom_range(0, 3) != 0);
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                        input logic etrc, input logic [31:0] etd);
    int   n;
    rsp_t r;
    trc_t t;
    r.rdata = erd;
    r.err   = eerr;
    exp_rsp.push_back(r);
    if (etrc) begin
      t.addr = {a[AW-1:2], 2'b00};
      t.data = etd;
      exp_trc.push_back(t);
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 200);
    if (!req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_f3    = 3'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    chk("rsp_latency", 32'(n), 32'(cur + 1));
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("drain", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] mdl [NI][DEPTH];

  // Reference model: byte-wise little-endian memory, independent of strobe/replication logic.
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                          input logic [31:0] wd);
    logic        bad, mis, oor, e;
    logic [31:0] w, rd;
    int          nb, off, wi;
    nb  = 1 << f3[1:0];
    off = int'(a[1:0]);
    wi  = int'(a) / 4;
    bad = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = (int'(a) % nb) != 0;
    oor = int'(a) >= DEPTH * 4;
    e   = bad || mis || oor;
    w   = '0;
    rd  = '0;
    if (!e) begin
      w = mdl[cur][wi];
      if (we) begin
        for (int k = 0; k < nb; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
        mdl[cur][wi] = w;
      end else begin
        case (f3)
          3'd0:    rd = 32'($signed(w[8*off +: 8]));
          3'd1:    rd = 32'($signed(w[8*off +: 16]));
          3'd4:    rd = {24'd0, w[8*off +: 8]};
          3'd5:    rd = {16'd0, w[8*off +: 16]};
          default: rd = w;
        endcase
      end
    end
    do_req(we, f3, a, wd, rd, e, we && !e, w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic          we, ok, quiet;
    logic [2:0]    f3;
    logic [AW-1:0] a;
    logic [31:0]   snap_rd;
    logic          snap_err;
    int            ntrc, lsel, n;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_f3 = '0; req_addr = '0; req_wdata = '0;
    bp_mode = 1'b0; rsp_ready_man = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_trc_valid", 32'(trc_valid), 32'd0);
    chk("reset_trc_data", trc_data, 32'd0);

    // LATENCY = 0 directed vectors
    do_req(1'b1, 3'd2, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    do_req(1'b1, 3'd0, 10'h013, 32'h00000080, 32'h0, 1'b0, 1'b1, 32'h80ADBEEF);
    do_req(1'b0, 3'd0, 10'h013, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0);
    do_req(1'b0, 3'd4, 10'h013, 32'h0, 32'h00000080, 1'b0, 1'b0, 32'h0);
    do_req(1'b0, 3'd1, 10'h012, 32'h0, 32'hFFFF80AD, 1'b0, 1'b0, 32'h0);
    do_req(1'b0, 3'd5, 10'h012, 32'h0, 32'h000080AD, 1'b0, 1'b0, 32'h0);
    do_req(1'b1, 3'd1, 10'h011, 32'h0000BEEF, 32'h0, 1'b1, 1'b0, 32'h0);
    do_req(1'b0, 3'd2, 10'h022, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    do_req(1'b0, 3'd0, 10'h200, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    do_req(1'b1, 3'd3, 10'h010, 32'h11111111, 32'h0, 1'b1, 1'b0, 32'h0);
    do_req(1'b0, 3'd6, 10'h010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    do_req(1'b0, 3'd2, 10'h010, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0, 32'h0);
    do_req(1'b1, 3'd1, 10'h012, 32'h5555CAFE, 32'h0, 1'b0, 1'b1, 32'hCAFEBEEF);
    do_req(1'b0, 3'd1, 10'h012, 32'h0, 32'hFFFFCAFE, 1'b0, 1'b0, 32'h0);
    do_req(1'b1, 3'd2, 10'h1FC, 32'h01234567, 32'h0, 1'b0, 1'b1, 32'h01234567);
    do_req(1'b0, 3'd2, 10'h1FC, 32'h0, 32'h01234567, 1'b0, 1'b0, 32'h0);
    do_req(1'b0, 3'd0, 10'h1FF, 32'h0, 32'h00000001, 1'b0, 1'b0, 32'h0);
    drain();

    // LATENCY = 3: response held under backpressure for 5 cycles
    cur = 3;
    rsp_ready_man = 1'b0;
    do_req(1'b1, 3'd2, 10'h020, 32'h0BADF00D, 32'h0, 1'b0, 1'b1, 32'h0BADF00D);
    snap_rd = rsp_rdata; snap_err = rsp_err; ntrc = 0; ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (!rsp_valid || rsp_rdata !== snap_rd || rsp_err !== snap_err || req_ready) ok = 1'b0;
      if (trc_valid) ntrc++;
      if (i == 4) begin @(posedge clk); #1 rsp_ready_man = 1'b1; end
    end
    chk("bp_stable_6_cycles", 32'(ok), 32'd1);
    chk("bp_trc_one_cycle", 32'(ntrc), 32'd1);
    @(negedge clk);
    chk("bp_ready_after_hs", 32'(req_ready), 32'd1);
    chk("bp_valid_after_hs", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 3'd2, 10'h020, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 32'h0);
    drain();

    // LATENCY = 3: reset during WAIT drops the store
    @(posedge clk); #1;
    req_we = 1'b1; req_f3 = 3'd2; req_addr = 10'h020; req_wdata = 32'h12345678; req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    @(posedge clk); #1 req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wait_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_wait_trc_addr", 32'(trc_addr), 32'd0);
    chk("rst_wait_trc_data", trc_data, 32'd0);
    quiet = 1'b1;
    repeat (8) begin @(negedge clk); if (rsp_valid || trc_valid) quiet = 1'b0; end
    chk("rst_wait_no_response", 32'(quiet), 32'd1);
    do_req(1'b0, 3'd2, 10'h020, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 32'h0);
    drain();

    // Random stream with backpressure on every latency
    bp_mode = 1'b1;
    for (int l = 0; l < NI; l++) begin
      cur = l;
      for (int w = 0; w < DEPTH; w++) model_op(1'b1, 3'd2, AW'(w * 4), $urandom);
      for (int i = 0; i < 60; i++) begin
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
        else if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          lsel = $urandom_range(0, 4);
          f3   = (lsel > 2) ? 3'(lsel + 1) : 3'(lsel);
        end
        a = AW'($urandom_range(0, DEPTH * 4 - 1));
        if ($urandom_range(0, 3) != 0) a = a & ~AW'((1 << f3[1:0]) - 1);
        if ($urandom_range(0, 9) == 0) a = AW'($urandom_range(DEPTH * 4, (1 << AW) - 1));
        model_op(we, f3, a, $urandom);
      end
      drain();
    end
    bp_mode = 1'b0;

    chk("exp_rsp_empty", 32'(exp_rsp.size()), 32'd0);
    chk("exp_trc_empty", 32'(exp_trc.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
